// File: rtl/q100_ifetch_if.sv
// q100_ifetch_if: fetch-to-decode handshake carrying {pc, instruction} pairs
interface q100_ifetch_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          if_valid_o;
  logic          if_ready_i;
  logic [DW-1:0] if_instr_o;
  logic [AW-1:0] if_pc_o;
  modport master (output if_valid_o, if_instr_o, if_pc_o, input if_ready_i);
  modport slave  (input if_valid_o, if_instr_o, if_pc_o, output if_ready_i);
endinterface

// File: rtl/q100_ifetch.sv
// q100_ifetch: PC owner, ITCM read issue, redirect flush and 2-entry buffer toward decode
module q100_ifetch #(
  parameter int                         ITCM_DATA_WIDTH = 32,
  parameter int                         ITCM_ADDR_WIDTH = 12,
  parameter logic [ITCM_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en_i,
  output logic [ITCM_ADDR_WIDTH-1:0] itcm_addr_o,
  input  logic [ITCM_DATA_WIDTH-1:0] itcm_data_i,
  input  logic                       redirect_valid_i,
  input  logic [ITCM_ADDR_WIDTH-1:0] redirect_pc_i,
  q100_ifetch_if.master              dec
);
  localparam int DW = ITCM_DATA_WIDTH;
  localparam int AW = ITCM_ADDR_WIDTH;
  logic [AW-1:0] pc_q, pc_d, infl_pc_q, infl_pc_d;
  logic          infl_q, infl_d;
  logic [1:0]    cnt_q, cnt_d, wr_idx;
  logic [AW-1:0] bpc_q [2];
  logic [AW-1:0] bpc_d [2];
  logic [DW-1:0] bin_q [2];
  logic [DW-1:0] bin_d [2];
  logic          has_buf, pop, pop_buf, push, issue;
  assign has_buf         = cnt_q != 2'd0;
  assign itcm_addr_o     = pc_q;
  assign dec.if_valid_o  = has_buf | infl_q;
  assign dec.if_instr_o  = has_buf ? bin_q[0] : infl_q ? itcm_data_i : '0;
  assign dec.if_pc_o     = has_buf ? bpc_q[0] : infl_q ? infl_pc_q : '0;
  assign pop             = dec.if_valid_o & dec.if_ready_i;
  assign pop_buf         = pop & has_buf;
  assign push            = infl_q & ~(pop & ~has_buf);
  assign wr_idx          = cnt_q - {1'b0, pop_buf};
  assign issue           = fetch_en_i & ~redirect_valid_i & ((cnt_q + {1'b0, infl_q} < 2'd2) | pop);
  // next state: shift out the popped head, append the returning response, redirect flushes all
  always_comb begin
    bpc_d = bpc_q;
    bin_d = bin_q;
    if (pop_buf) begin
      bpc_d[0] = bpc_q[1];
      bin_d[0] = bin_q[1];
    end
    if (push) begin
      bpc_d[wr_idx[0]] = infl_pc_q;
      bin_d[wr_idx[0]] = itcm_data_i;
    end
    cnt_d     = redirect_valid_i ? 2'd0 : wr_idx + {1'b0, push};
    infl_d    = issue;
    infl_pc_d = pc_q;
    pc_d      = redirect_valid_i ? (redirect_pc_i & ~AW'(3)) : issue ? pc_q + AW'(4) : pc_q;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      cnt_q     <= 2'd0;
      bpc_q[0]  <= '0;
      bpc_q[1]  <= '0;
      bin_q[0]  <= '0;
      bin_q[1]  <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      cnt_q     <= cnt_d;
      bpc_q[0]  <= bpc_d[0];
      bpc_q[1]  <= bpc_d[1];
      bin_q[0]  <= bin_d[0];
      bin_q[1]  <= bin_d[1];
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && wr_idx == 2'd2));
endmodule

// File: tb/tb_q100_ifetch.sv
// tb_q100_ifetch: table vectors plus in-order scoreboard for the fetch stage
module tb_q100_ifetch;
  logic        clk = 0, rst = 0, fetch_en = 0, redirect = 0;
  logic [11:0] rpc = 0, iaddr;
  logic [31:0] idata = 0;
  int          total = 0, bad = 0, npop = 0, n0 = 0;
  logic [11:0] exp_q[$];
  typedef struct {
    logic        fen;
    logic        rdy;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [11:0] e_pc;
  } vec_t;
  vec_t tv[12];

  q100_ifetch_if #(.DW(32), .AW(12)) dec ();

  q100_ifetch #(.ITCM_DATA_WIDTH(32), .ITCM_ADDR_WIDTH(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .itcm_addr_o(iaddr), .itcm_data_i(idata),
    .redirect_valid_i(redirect), .redirect_pc_i(rpc), .dec(dec.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) idata <= 32'h1000 + 32'(iaddr >> 2);

  function automatic logic [31:0] word(input logic [11:0] pc);
    return 32'h1000 + 32'(pc >> 2);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic fill(input logic [11:0] s);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(s + 12'(4 * i));
  endtask

  task automatic out(input string n, input logic [11:0] a, input logic v, input logic [11:0] pc);
    chk({n, "_addr"}, 32'(iaddr), 32'(a));
    chk({n, "_valid"}, 32'(dec.if_valid_o), 32'(v));
    chk({n, "_pc"}, 32'(dec.if_pc_o), 32'(pc));
    chk({n, "_instr"}, dec.if_instr_o, v ? word(pc) : 32'h0);
  endtask

  task automatic cyc(input logic fen, input logic rdy, input logic red, input logic [11:0] p);
    logic [11:0] e;
    @(negedge clk);
    fetch_en = fen;
    dec.if_ready_i = rdy;
    redirect = red;
    rpc = p;
    #1;
    if (dec.if_valid_o && rdy) begin
      npop++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got pc %0h expected none", dec.if_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(dec.if_pc_o), 32'(e));
        chk("sb_instr", dec.if_instr_o, word(e));
      end
    end
    if (red) fill(p & 12'hFFC);
  endtask

  initial begin
    dec.if_ready_i = 0;
    tv[0]  = '{1, 1, 12'h000, 0, 12'h000};
    tv[1]  = '{1, 1, 12'h004, 1, 12'h000};
    tv[2]  = '{1, 1, 12'h008, 1, 12'h004};
    tv[3]  = '{1, 0, 12'h00C, 1, 12'h008};
    tv[4]  = '{1, 0, 12'h010, 1, 12'h008};
    tv[5]  = '{1, 0, 12'h010, 1, 12'h008};
    tv[6]  = '{1, 0, 12'h010, 1, 12'h008};
    tv[7]  = '{1, 0, 12'h010, 1, 12'h008};
    tv[8]  = '{1, 1, 12'h010, 1, 12'h008};
    tv[9]  = '{1, 1, 12'h014, 1, 12'h00C};
    tv[10] = '{1, 1, 12'h018, 1, 12'h010};
    tv[11] = '{1, 1, 12'h01C, 1, 12'h014};
    repeat (3) @(negedge clk);
    #1;
    out("rst", 12'h000, 0, 12'h000);
    rst = 1;
    fill(12'h000);
    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].fen, tv[i].rdy, 0, 0);
      out($sformatf("vec%0d", i), tv[i].e_addr, tv[i].e_valid, tv[i].e_pc);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    out("stall_full", 12'h020, 1, 12'h018);
    cyc(1, 0, 1, 12'h203);
    out("redir_cyc", 12'h020, 1, 12'h018);
    cyc(1, 1, 0, 0);
    out("redir_t1", 12'h200, 0, 12'h000);
    cyc(1, 1, 0, 0);
    out("redir_t2", 12'h204, 1, 12'h200);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 12'hFFC);
    cyc(1, 1, 0, 0);
    out("wrap_t1", 12'hFFC, 0, 12'h000);
    cyc(1, 1, 0, 0);
    out("wrap_t2", 12'h000, 1, 12'hFFC);
    cyc(1, 1, 0, 0);
    out("wrap_t3", 12'h004, 1, 12'h000);
    cyc(1, 1, 0, 0);
    out("wrap_t4", 12'h008, 1, 12'h004);
    cyc(1, 1, 1, 12'h100);
    cyc(1, 1, 1, 12'h300);
    out("b2b_2", 12'h100, 0, 12'h000);
    cyc(1, 1, 0, 0);
    out("b2b_t1", 12'h300, 0, 12'h000);
    cyc(1, 1, 0, 0);
    out("b2b_t2", 12'h304, 1, 12'h300);
    repeat (3) cyc(1, 0, 0, 0);
    out("fen_full", 12'h30C, 1, 12'h304);
    n0 = npop;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      chk("fen_addr", 32'(iaddr), 32'h30C);
    end
    chk("fen_drain", npop - n0, 2);
    out("fen_idle", 12'h30C, 0, 12'h000);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    out("pre_arst", 12'h310, 1, 12'h30C);
    rst = 0;
    #1;
    out("arst", 12'h000, 0, 12'h000);
    fill(12'h000);
    @(negedge clk);
    fetch_en = 0;
    #1;
    rst = 1;
    cyc(1, 1, 0, 0);
    out("post_rst0", 12'h000, 0, 12'h000);
    cyc(1, 1, 0, 0);
    out("post_rst1", 12'h004, 1, 12'h000);
    repeat (10) cyc(1, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/q100_ifetch.md
Name: q100_ifetch

Overview:
Instruction fetch stage that drives the ITCM read port and delivers {pc, instruction} pairs to decode over a valid/ready handshake. It owns the PC register, sequential increment, redirect (branch/jump/trap) handling, and a 2-entry output buffer. The buffer absorbs the ITCM's fixed 1-cycle read latency when decode stalls. The block never writes the ITCM; the top level ties itcm_we_i low on the fetch port.

Parameters:
ITCM_DATA_WIDTH, 32, instruction width.
ITCM_ADDR_WIDTH, 12, byte-address width of the ITCM; PC width.
RESET_PC, 0, byte address fetched first after reset; must be 4-byte aligned.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
fetch_en_i  input  1  permits issuing new ITCM reads.
itcm_addr_o  output  ITCM_ADDR_WIDTH  ITCM byte address, equal to pc_q.
itcm_data_i  input  ITCM_DATA_WIDTH  ITCM read data, valid 1 cycle after the address.
redirect_valid_i  input  1  flush the pipeline and refetch from redirect_pc_i.
redirect_pc_i  input  ITCM_ADDR_WIDTH  redirect target; bits [1:0] ignored.
if_valid_o  output  1  instruction available to decode.
if_ready_i  input  1  decode accepts the instruction.
if_instr_o  output  ITCM_DATA_WIDTH  instruction word.
if_pc_o  output  ITCM_ADDR_WIDTH  byte address of if_instr_o.

Behaviour:
- Reset (rst=0, async) sets: pc_q=RESET_PC, inflight=0, buffer count=0. Outputs while in reset: itcm_addr_o=RESET_PC, if_valid_o=0, if_instr_o=0, if_pc_o=0.
- State:
  - pc_q: address of the next read.
  - inflight: 1 bit, set if a read was issued last cycle; carries its PC.
  - buf[0..1]: FIFO of {pc, instr}; count ranges 0..2.
- Issue rule:
  - issue = fetch_en_i && !redirect_valid_i && (count + inflight < 2 || pop).
  - pop = if_valid_o && if_ready_i.
  - On issue: inflight<=1 with pc_q; pc_q <= pc_q+4 modulo 2^ITCM_ADDR_WIDTH (wraps to 0).
  - No issue: pc_q holds, inflight<=0. The ITCM still reads pc_q each cycle; that data is discarded.
- Response: when inflight=1, itcm_data_i is the instruction for inflight_pc.
- Output select:
  - count>0: present buf head.
  - count=0 and inflight=1: bypass itcm_data_i and inflight_pc directly.
  - otherwise: if_valid_o=0, and if_instr_o/if_pc_o are driven 0.
- Buffer update per cycle: the response is written to the buffer unless it is consumed through the bypass in the same cycle. Pop removes the head. count must never exceed 2; an overflow is an assertion failure.
- Outputs are stable while if_valid_o=1 and if_ready_i=0 (the bypass case cannot stall, because a stalled response is captured into buf).
- Redirect (highest priority):
  - In the cycle redirect_valid_i=1, a pop completes normally if handshaken.
  - Next edge: count<=0, inflight<=0, pc_q <= {redirect_pc_i[ADDR-1:2],2'b00}.
  - No issue occurs in the redirect cycle.
  - Latency: redirect at cycle T -> target address on itcm_addr_o at T+1 -> if_valid_o with the target instruction at T+2 (if fetch_en_i=1).
- Back-to-back redirects: the last one wins; each one flushes.
- fetch_en_i=0: buffered and inflight entries still drain; no new reads are issued.
- Throughput: 1 instruction per cycle sustained while if_ready_i=1.
- Reset asserted mid-operation discards all state immediately; the first fetch after deassertion is RESET_PC.

Test Plan:
- Reset release, fetch_en_i=1, if_ready_i=1, ITCM preloaded mem[i]=0x1000+i -> itcm_addr_o 0,4,8,... each cycle; if_valid_o rises in the 2nd cycle with pc=0/instr=0x1000, then pc=4/0x1001, no gaps.
- Streaming, then if_ready_i=0 for 5 cycles -> count settles at 2; if_instr_o/if_pc_o held; pc_q stops advancing. On release, the sequence resumes with no drop or duplicate.
- redirect_valid_i=1, redirect_pc_i=0x203 while count=2 and inflight=1 -> buffered entries discarded; itcm_addr_o=0x200 next cycle; the next delivered pair is pc=0x200 two cycles after the redirect.
- Redirect to 0xFFC (ITCM_ADDR_WIDTH=12) -> delivered pcs 0xFFC, then 0x000, 0x004 (wrap).
- fetch_en_i deasserted with 2 buffered entries, if_ready_i=1 -> exactly 2 more instructions (plus any inflight one) are delivered, then if_valid_o=0 and itcm_addr_o is constant.
- rst pulsed low mid-stream with if_valid_o=1 -> if_valid_o=0 immediately (async); after release, the first delivered pc=RESET_PC.
